// File: rtl/cache_line_mem_ctrl.sv
// Memory-side burst engine: writes back dirty lines and fetches fill lines
// one word at a time over a single-outstanding req/ack bus.
module cache_line_mem_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             wb_req,
    input  logic                             fill_req,
    input  logic [ADDR_W-1:0]                wb_addr,
    input  logic [ADDR_W-1:0]                fill_addr,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] wb_line,
    output logic [DATA_W*WORDS_PER_LINE-1:0] fill_line,
    output logic                             busy,
    output logic                             done,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_ack,
    input  logic [DATA_W-1:0]                mem_rdata
);

    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int OFF    = IDX_W + 2;
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [ADDR_W-1:0]  wb_addr_q, fill_addr_q;
    logic [LINE_W-1:0]  wb_buf;
    logic               fill_pend;
    logic               last_word;
    logic [ADDR_W-1:0]  word_off;

    assign last_word = (idx == LAST_IDX);
    assign word_off  = ADDR_W'({idx, 2'b00});

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (wb_req)        state_nxt = S_WB;
                else if (fill_req) state_nxt = S_FILL;
            end
            S_WB: begin
                if (mem_ack && last_word) state_nxt = fill_pend ? S_FILL : S_DONE;
            end
            S_FILL: begin
                if (mem_ack && last_word) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word index and assembled fill line; both are architecturally visible, so reset them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx       <= '0;
            fill_line <= '0;
        end else begin
            unique case (state)
                S_WB: begin
                    if (mem_ack) idx <= last_word ? '0 : idx + 1'b1;
                end
                S_FILL: begin
                    if (mem_ack) begin
                        fill_line[idx*DATA_W +: DATA_W] <= mem_rdata;
                        idx <= last_word ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: request captures are only read outside IDLE, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE) begin
            if (wb_req) begin
                wb_addr_q   <= wb_addr;
                wb_buf      <= wb_line;
                fill_addr_q <= fill_addr;
                fill_pend   <= fill_req;
            end else if (fill_req) begin
                fill_addr_q <= fill_addr;
                fill_pend   <= 1'b0;
            end
        end
    end

    // Bus outputs decode from state and registered captures only, never from mem_ack.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_WB: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = (wb_addr_q & ~LINE_MASK) | word_off;
                mem_wdata = wb_buf[idx*DATA_W +: DATA_W];
            end
            S_FILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = (fill_addr_q & ~LINE_MASK) | word_off;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_line_mem_ctrl.md
Name: cache_line_mem_ctrl

Overview:
- Memory-side burst engine directly downstream of the data-cache controller FSM.
- Executes the cache's dirty-line writebacks and line fills as word-by-word transactions on a single-outstanding req/ack memory bus.
- Assembles fill data into a full line buffer for the cache array.
- Raises busy while working and pulses done when finished, so the controller FSM can hold stall and leave its WRITE_BACK/LOAD states.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, ≥2.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; word stride on the bus is 4 bytes.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- wb_req  in  1  writeback request; level, sampled only in IDLE.
- fill_req  in  1  line-fill request; level, sampled only in IDLE.
- wb_addr  in  ADDR_W  any byte address inside the victim line.
- fill_addr  in  ADDR_W  any byte address inside the line to fetch.
- wb_line  in  DATA_W*WORDS_PER_LINE  dirty line data; word i occupies bits [i*DATA_W +: DATA_W].
- fill_line  out  DATA_W*WORDS_PER_LINE  assembled fill data, same packing as wb_line.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word byte-address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory completes the current word this cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.

Behaviour:
- Reset: RST is synchronous, active-high, clock CLK. On reset:
  - state=IDLE, word index=0.
  - busy, done, mem_req, mem_we all 0.
  - mem_addr, mem_wdata, fill_line all 0.
  - Reset mid-burst aborts with no done; mem_req is 0 from the first cycle after the reset edge.
- OFF = log2(WORDS_PER_LINE)+2. Line base = address with the low OFF bits cleared.
- Word address = base + 4*idx, with idx running 0..WORDS_PER_LINE-1 in ascending order.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - wb_req=1: capture wb_addr, wb_line and fill_req/fill_addr; go to WB.
  - Only fill_req=1: capture fill_addr; go to FILL.
  - Neither: stay in IDLE.
- WB:
  - Drives mem_req=1, mem_we=1, mem_addr=word address, mem_wdata=captured word idx.
  - Outputs hold stable until mem_ack.
  - On mem_ack: idx increments.
  - On the last word's ack: idx resets to 0. Go to FILL if a fill was captured, else go to DONE.
- FILL:
  - Drives mem_req=1, mem_we=0.
  - On mem_ack: fill_line word idx <= mem_rdata and idx increments.
  - On the last ack: idx=0, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, mem_req=0; then go to IDLE.
- Simultaneous wb_req and fill_req: writeback runs first, then fill, with a single done at the end. No idle cycle between the two bursts.
- Zero-wait memory (ack in the first req cycle): one word per cycle.
- Latency: accept at edge 0 → first mem_req in cycle 1.
  - Fill only: done in cycle WORDS_PER_LINE+1 plus total wait cycles.
  - Combined writeback+fill: done in cycle 2*WORDS_PER_LINE+1 plus total wait cycles.
- mem_ack while mem_req=0: ignored.
- wb_req/fill_req while busy: ignored, including in DONE.
- Input changes after acceptance have no effect on the burst in progress.
- fill_line holds its value until the next fill overwrites it word by word; a writeback-only burst does not modify it.
- No combinational path from mem_ack or mem_rdata to any output. All outputs are registered or decoded from state.

Test Plan:
- Zero-wait fill: fill_addr=0x0000_1234, mem_ack tied 1, mem_rdata=0xA0,0xA1,0xA2,0xA3 → mem_addr=0x1230,0x1234,0x1238,0x123C in cycles 1–4 with mem_we=0; done=1 in cycle 5 only; fill_line={0xA3,0xA2,0xA1,0xA0}; busy=0 in cycle 6.
- Writeback with waits: wb_addr=0x0000_2000, wb_line words 0x11,0x22,0x33,0x44, ack after 2 wait cycles per word → each mem_addr/mem_wdata held 3 cycles, mem_we=1 throughout; done in cycle 13; fill_line unchanged.
- Combined: wb_req=fill_req=1, wb_addr=0x2000, fill_addr=0x3008, zero-wait → writes to 0x2000–0x200C in cycles 1–4, then reads from 0x3000–0x300C in cycles 5–8; single done in cycle 9.
- Reset mid-burst: RST=1 during the second fill word → next cycle mem_req=0, busy=0, fill_line=0, no done; a new fill after reset starts at idx 0.
- Noise while busy: wb_req pulsed in cycles 2 and 5 of a fill, and stray mem_ack while in IDLE/DONE → no extra burst starts, no extra done, fill_line unaffected.
